// File: rtl/csr_req_ctrl_if.sv
// csr_req_ctrl_if: bundles the instruction request, CSR bus and writeback
// signals of the CSR request controller. master = controller, slave = env.
interface csr_req_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_funct3;
  logic [4:0]            req_rd;
  logic [4:0]            req_rs1;
  logic [REG_WIDTH-1:0]  req_rs1_val;
  logic [ADDR_WIDTH-1:0] req_csr_addr;
  logic [ID_WIDTH-1:0]   req_id;
  logic                  flush;
  logic [1:0]            csr_op;
  logic [2:0]            csr_funct3;
  logic [4:0]            csr_imm;
  logic [REG_WIDTH-1:0]  rs1_val;
  logic [ADDR_WIDTH-1:0] csr_addr;
  logic                  csr_valid;
  logic                  csr_rrsp;
  logic [ADDR_WIDTH-1:0] csr_rdata;
  logic                  csr_rvalid;
  logic [2:0]            csr_reg_rsp;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ID_WIDTH-1:0]   wb_id;
  logic                  wb_rd_en;
  logic [4:0]            wb_rd;
  logic [REG_WIDTH-1:0]  wb_data;
  logic                  wb_exc;
  logic [1:0]            wb_cause;

  modport master (
    input  req_valid, req_funct3, req_rd, req_rs1, req_rs1_val,
    input  req_csr_addr, req_id, flush,
    input  csr_rdata, csr_rvalid, csr_reg_rsp, wb_ready,
    output req_ready, csr_op, csr_funct3, csr_imm, rs1_val, csr_addr,
    output csr_valid, csr_rrsp,
    output wb_valid, wb_id, wb_rd_en, wb_rd, wb_data, wb_exc, wb_cause
  );

  modport slave (
    output req_valid, req_funct3, req_rd, req_rs1, req_rs1_val,
    output req_csr_addr, req_id, flush,
    output csr_rdata, csr_rvalid, csr_reg_rsp, wb_ready,
    input  req_ready, csr_op, csr_funct3, csr_imm, rs1_val, csr_addr,
    input  csr_valid, csr_rrsp,
    input  wb_valid, wb_id, wb_rd_en, wb_rd, wb_data, wb_exc, wb_cause
  );
endinterface

// File: rtl/csr_req_ctrl.sv
// csr_req_ctrl: blocking CSR issue stage. Takes one decoded CSR instruction,
// issues it on the CSR bus, waits (bounded) for the response, returns result.
// Ports: clk, rst_n (sync, active low), io (csr_req_ctrl_if.master):
//   req_* in / req_ready out, flush, csr_* bus request/response, wb_* result.
module csr_req_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32,
  parameter int ID_WIDTH   = 4,
  parameter int TIMEOUT    = 16
) (
  input logic             clk,
  input logic             rst_n,
  csr_req_ctrl_if.master  io
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RESP, DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [4:0]            imm_q, imm_d;
  logic [REG_WIDTH-1:0]  rs1_val_q, rs1_val_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [4:0]            rd_q, rd_d;
  logic [REG_WIDTH-1:0]  data_q, data_d;
  logic                  exc_q, exc_d;
  logic [1:0]            cause_q, cause_d;
  logic                  rd_en_q, rd_en_d;

  logic req_ready;
  logic csr_valid;
  logic csr_rrsp;
  logic wb_valid;
  logic illegal;

  assign illegal = (io.req_funct3[1:0] == 2'b00);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    funct3_d  = funct3_q;
    imm_d     = imm_q;
    rs1_val_d = rs1_val_q;
    addr_d    = addr_q;
    id_d      = id_q;
    rd_d      = rd_q;
    data_d    = data_q;
    exc_d     = exc_q;
    cause_d   = cause_q;
    rd_en_d   = rd_en_q;
    req_ready = 1'b0;
    csr_valid = 1'b0;
    csr_rrsp  = 1'b0;
    wb_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = !io.flush;
        if (io.req_valid && req_ready) begin
          op_d[1]   = !(io.req_funct3[1:0] == 2'b01
                        && io.req_rd == 5'd0);
          op_d[0]   = (io.req_funct3[1:0] == 2'b01)
                      || (io.req_rs1 != 5'd0);
          funct3_d  = io.req_funct3;
          imm_d     = io.req_rs1;
          rs1_val_d = io.req_rs1_val;
          addr_d    = io.req_csr_addr;
          id_d      = io.req_id;
          rd_d      = io.req_rd;
          if (illegal) begin
            data_d  = '0;
            exc_d   = 1'b1;
            cause_d = 2'b10;
            rd_en_d = 1'b0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE, WAIT, DRAIN: begin
        csr_valid = (state_q == ISSUE);
        cnt_d = (state_q == ISSUE) ? CW'(1) : cnt_q + CW'(1);
        if (io.csr_rvalid) begin
          csr_rrsp = 1'b1;
          data_d   = REG_WIDTH'(io.csr_rdata);
          exc_d    = io.csr_reg_rsp[2];
          cause_d  = io.csr_reg_rsp[1:0];
          rd_en_d  = op_q[1] && (rd_q != 5'd0)
                     && !io.csr_reg_rsp[2];
          // a killed instruction still consumes its response
          state_d  = (io.flush || state_q == DRAIN) ? IDLE : RESP;
        end else if (state_q != ISSUE && cnt_q == TO) begin
          data_d   = '0;
          exc_d    = 1'b1;
          cause_d  = 2'b11;
          rd_en_d  = 1'b0;
          state_d  = (io.flush || state_q == DRAIN) ? IDLE : RESP;
        end else if (io.flush || state_q == DRAIN) begin
          state_d  = DRAIN;
        end else begin
          state_d  = WAIT;
        end
      end
      RESP: begin
        wb_valid = 1'b1;
        if (io.wb_ready || io.flush) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      funct3_q  <= '0;
      imm_q     <= '0;
      rs1_val_q <= '0;
      addr_q    <= '0;
      id_q      <= '0;
      rd_q      <= '0;
      data_q    <= '0;
      exc_q     <= 1'b0;
      cause_q   <= '0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      funct3_q  <= funct3_d;
      imm_q     <= imm_d;
      rs1_val_q <= rs1_val_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      exc_q     <= exc_d;
      cause_q   <= cause_d;
      rd_en_q   <= rd_en_d;
    end
  end

  assign io.req_ready  = req_ready;
  assign io.csr_valid  = csr_valid;
  assign io.csr_rrsp   = csr_rrsp;
  assign io.csr_op     = op_q;
  assign io.csr_funct3 = funct3_q;
  assign io.csr_imm    = imm_q;
  assign io.rs1_val    = rs1_val_q;
  assign io.csr_addr   = addr_q;
  assign io.wb_valid   = wb_valid;
  assign io.wb_id      = id_q;
  assign io.wb_rd_en   = rd_en_q;
  assign io.wb_rd      = rd_q;
  assign io.wb_data    = data_q;
  assign io.wb_exc     = exc_q;
  assign io.wb_cause   = cause_q;
endmodule

// File: tb/tb_csr_req_ctrl.sv
// tb_csr_req_ctrl: directed + random stimulus for csr_req_ctrl, checked
// every cycle against a transaction-level model of the controller.
module tb_csr_req_ctrl;
  localparam int AW = 32;
  localparam int RW = 32;
  localparam int IW = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csr_req_ctrl_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW), .ID_WIDTH(IW)) bus ();

  csr_req_ctrl #(
    .ADDR_WIDTH(AW), .REG_WIDTH(RW), .ID_WIDTH(IW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io(bus)
  );

  int total = 0;
  int bad = 0;

  // model: one instruction in flight, tracked by age since its bus request
  bit          m_busy, m_legal, m_res, m_killed, m_known;
  int          m_age;
  logic [1:0]  m_op;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd, m_imm;
  logic [RW-1:0] m_rs1v, m_data;
  logic [AW-1:0] m_addr;
  logic [IW-1:0] m_id;
  bit          m_exc, m_rden;
  logic [1:0]  m_cause;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cb();
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    bus.csr_rvalid = 1'b0;
    bus.csr_rdata = $urandom;
    bus.csr_reg_rsp = 3'b000;
    bus.wb_ready = 1'b0;
  endtask

  task automatic put_req(input logic [2:0] f3, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [RW-1:0] v,
                         input logic [AW-1:0] a, input logic [IW-1:0] id);
    bus.req_valid = 1'b1;
    bus.req_funct3 = f3;
    bus.req_rd = rd;
    bus.req_rs1 = rs1;
    bus.req_rs1_val = v;
    bus.req_csr_addr = a;
    bus.req_id = id;
  endtask

  task automatic compare();
    bit waiting;
    waiting = m_busy && m_legal && !m_res;
    chk("req_ready", bus.req_ready, !m_busy && !bus.flush);
    chk("csr_valid", bus.csr_valid, waiting && !m_killed && m_age == 0);
    chk("csr_rrsp", bus.csr_rrsp, waiting && bus.csr_rvalid);
    chk("wb_valid", bus.wb_valid, m_res);
    if (waiting) begin
      chk("csr_op", bus.csr_op, m_op);
      chk("csr_funct3", bus.csr_funct3, m_f3);
      chk("csr_imm", bus.csr_imm, m_imm);
      chk("rs1_val", bus.rs1_val, m_rs1v);
      chk("csr_addr", bus.csr_addr, m_addr);
    end
    if (m_res) begin
      chk("wb_id", bus.wb_id, m_id);
      chk("wb_rd", bus.wb_rd, m_rd);
      chk("wb_exc", bus.wb_exc, m_exc);
      chk("wb_cause", bus.wb_cause, m_cause);
      chk("wb_rd_en", bus.wb_rd_en, m_rden);
      if (m_known) chk("wb_data", bus.wb_data, m_data);
    end
  endtask

  task automatic update();
    bit drop;
    if (!rst_n) begin
      m_busy = 0;
      m_res = 0;
      m_killed = 0;
      return;
    end
    if (!m_busy) begin
      if (bus.req_valid && !bus.flush) begin
        m_busy = 1;
        m_killed = 0;
        m_age = 0;
        m_f3 = bus.req_funct3;
        m_rd = bus.req_rd;
        m_imm = bus.req_rs1;
        m_rs1v = bus.req_rs1_val;
        m_addr = bus.req_csr_addr;
        m_id = bus.req_id;
        m_op[1] = !(m_f3[1:0] == 2'b01 && m_rd == 0);
        m_op[0] = (m_f3[1:0] == 2'b01) || (m_imm != 0);
        m_legal = !(m_f3 == 3'b000 || m_f3 == 3'b100);
        if (!m_legal) begin
          m_res = 1;
          m_exc = 1;
          m_cause = 2'b10;
          m_rden = 0;
          m_known = 0;
        end
      end
    end else if (m_res) begin
      if (bus.wb_ready || bus.flush) begin
        m_busy = 0;
        m_res = 0;
      end
    end else begin
      drop = m_killed || bus.flush;
      if (bus.csr_rvalid) begin
        if (drop) m_busy = 0;
        else begin
          m_res = 1;
          m_exc = bus.csr_reg_rsp[2];
          m_cause = bus.csr_reg_rsp[1:0];
          m_data = RW'(bus.csr_rdata);
          m_known = 1;
          m_rden = m_op[1] && m_rd != 0 && !bus.csr_reg_rsp[2];
        end
      end else if (m_age == TO) begin
        if (drop) m_busy = 0;
        else begin
          m_res = 1;
          m_exc = 1;
          m_cause = 2'b11;
          m_rden = 0;
          m_known = 0;
        end
      end else begin
        if (bus.flush) m_killed = 1;
        m_age++;
      end
    end
  endtask

  task automatic ce();
    #1;
    if (rst_n) compare();
    update();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    cb(); rst_n = 1'b0; ce();
    cb(); rst_n = 1'b0; ce();
    cb(); ce();
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_valid", bus.csr_valid, 0);
    chk("rst_rrsp", bus.csr_rrsp, 0);
    chk("rst_op", bus.csr_op, 0);
    chk("rst_wbv", bus.wb_valid, 0);
    chk("rst_wbdata", bus.wb_data, 0);
    chk("rst_wbexc", bus.wb_exc, 0);

    // CSRRW with response in the issue cycle
    cb(); put_req(3'b001, 5, 3, 32'hDEADBEEF, 32'h3A0, 1); ce();
    chk("t1_ready", bus.req_ready, 1);
    cb(); bus.csr_rvalid = 1; bus.csr_rdata = 32'h1234; ce();
    chk("t1_valid", bus.csr_valid, 1);
    chk("t1_op", bus.csr_op, 2'b11);
    chk("t1_rrsp", bus.csr_rrsp, 1);
    chk("t1_rs1v", bus.rs1_val, 32'hDEADBEEF);
    cb(); bus.wb_ready = 1; ce();
    chk("t1_wbv", bus.wb_valid, 1);
    chk("t1_rden", bus.wb_rd_en, 1);
    chk("t1_data", bus.wb_data, 32'h1234);
    chk("t1_exc", bus.wb_exc, 0);

    // back-to-back CSRRS rs1=0 rd=0
    cb(); put_req(3'b010, 0, 0, 32'h1, 32'h3B0, 2); ce();
    chk("t2_ready", bus.req_ready, 1);
    cb(); bus.csr_rvalid = 1; bus.csr_rdata = 32'h55; ce();
    chk("t2_op", bus.csr_op, 2'b10);
    cb(); bus.wb_ready = 1; ce();
    chk("t2_rden", bus.wb_rd_en, 0);

    // CSRRW rd=0, response one cycle after issue
    cb(); put_req(3'b001, 0, 7, 32'h77, 32'h340, 3); ce();
    cb(); ce();
    chk("t3_op", bus.csr_op, 2'b01);
    chk("t3_valid", bus.csr_valid, 1);
    cb(); bus.csr_rvalid = 1; ce();
    chk("t3_wait_valid", bus.csr_valid, 0);
    chk("t3_rrsp", bus.csr_rrsp, 1);
    cb(); bus.wb_ready = 1; ce();

    // bus reports exception
    cb(); put_req(3'b010, 4, 0, 32'h0, 32'h300, 4); ce();
    cb(); bus.csr_rvalid = 1; bus.csr_reg_rsp = 3'b101; ce();
    cb(); bus.wb_ready = 1; ce();
    chk("t4_exc", bus.wb_exc, 1);
    chk("t4_cause", bus.wb_cause, 2'b01);
    chk("t4_rden", bus.wb_rd_en, 0);

    // illegal funct3, writeback stalled 4 cycles
    cb(); put_req(3'b100, 6, 1, 32'h9, 32'h305, 5); ce();
    for (int k = 0; k < 4; k++) begin
      cb(); put_req(3'b001, 1, 1, 32'h1, 32'h1, 9); ce();
      chk("t5_wbv", bus.wb_valid, 1);
      chk("t5_csrv", bus.csr_valid, 0);
      chk("t5_ready", bus.req_ready, 0);
    end
    chk("t5_cause", bus.wb_cause, 2'b10);
    cb(); bus.wb_ready = 1; ce();
    cb(); ce();
    chk("t5_idle", bus.req_ready, 1);

    // unmapped CSR: timeout
    cb(); put_req(3'b011, 2, 0, 32'h0, 32'h7C0, 6); ce();
    for (int k = 1; k <= 17; k++) begin
      cb(); put_req(3'b001, 1, 1, 32'h1, 32'h1, 9); ce();
      chk("t6_ready", bus.req_ready, 0);
      chk("t6_rrsp", bus.csr_rrsp, 0);
    end
    cb(); ce();
    chk("t6_wbv", bus.wb_valid, 1);
    chk("t6_exc", bus.wb_exc, 1);
    chk("t6_cause", bus.wb_cause, 2'b11);
    cb(); bus.wb_ready = 1; ce();

    // flush while waiting; late response acked and dropped
    cb(); put_req(3'b001, 9, 0, 32'h5, 32'h3A1, 7); ce();
    cb(); ce();
    cb(); ce();
    cb(); bus.flush = 1; ce();
    cb(); ce();
    cb(); ce();
    cb(); bus.csr_rvalid = 1; ce();
    chk("t7_rrsp", bus.csr_rrsp, 1);
    chk("t7_wbv", bus.wb_valid, 0);
    cb(); ce();
    chk("t7_idle", bus.req_ready, 1);

    // flush in idle blocks accept; flush in RESP drops result
    cb(); put_req(3'b001, 1, 1, 32'h1, 32'h1, 8); bus.flush = 1; ce();
    chk("t8_ready", bus.req_ready, 0);
    cb(); ce();
    chk("t8_noissue", bus.csr_valid, 0);
    cb(); put_req(3'b000, 1, 1, 32'h1, 32'h1, 8); ce();
    cb(); bus.flush = 1; ce();
    cb(); ce();
    chk("t9_wbv", bus.wb_valid, 0);

    // reset mid-operation drops the outstanding response
    cb(); put_req(3'b011, 3, 2, 32'h2, 32'h3A2, 10); ce();
    cb(); ce();
    cb(); rst_n = 1'b0; ce();
    cb(); bus.csr_rvalid = 1; ce();
    chk("t10_rrsp", bus.csr_rrsp, 0);
    chk("t10_ready", bus.req_ready, 1);

    quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) quiet = ($urandom_range(0, 2) == 0);
      cb();
      rst_n = ($urandom_range(0, 299) != 0);
      bus.req_valid = $urandom_range(0, 1);
      bus.req_funct3 = 3'($urandom_range(0, 7));
      bus.req_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      bus.req_rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      bus.req_rs1_val = $urandom;
      bus.req_csr_addr = $urandom;
      bus.req_id = IW'($urandom);
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.csr_rvalid = !quiet && ($urandom_range(0, 3) == 0);
      bus.csr_reg_rsp = 3'($urandom);
      bus.wb_ready = $urandom_range(0, 1);
      ce();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
